// File: rtl/pe_out_collector_pkg.sv
// Shared definitions for the PE output collector: datapath width and the stored word layout.
package pe_out_collector_pkg;

  localparam int dwidth_float = 64;

  typedef struct packed {
    logic                    last;
    logic [dwidth_float-1:0] data;
  } pe_word_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; the head entry is visible whenever head_valid is high.
module sync_fifo_fwft #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full,
  output logic [CW-1:0]    count_next
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             valid_r;
  logic             wr_s;
  logic             rd_s;
  logic [CW-1:0]    count_next_s;

  assign full       = (count_r == FULL_C);
  assign wr_s       = push && !full;
  assign rd_s       = pop && valid_r;
  assign head_data  = mem_r[rd_ptr_r];
  assign head_valid = valid_r;
  assign count_next = count_next_s;

  // Occupancy after this cycle's write/read pair.
  always_comb begin
    count_next_s = count_r;
    case ({wr_s, rd_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage array; deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; valid follows next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != {CW{1'b0}});
    end
  end

endmodule

// File: rtl/pe_out_collector.sv
// Collects PE results into an AXI-stream FIFO; drops on full (PE cannot be stalled) and
// tracks overflow, almost-full and emitted-packet count.
module pe_out_collector
  import pe_out_collector_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [dwidth_float-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic [dwidth_float-1:0] m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic                    almost_full,
  output logic                    overflow,
  input  logic                    clr_overflow,
  output logic [15:0]             pkt_count
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  pe_word_t      push_word_s;
  pe_word_t      head_word_s;
  logic          head_valid_s;
  logic          full_s;
  logic [CW-1:0] count_next_s;
  logic          drop_s;
  logic          rd_s;
  logic          overflow_r;
  logic          almost_full_r;
  logic [15:0]   pkt_count_r;

  assign push_word_s = '{last: in_last, data: in_data};

  sync_fifo_fwft #(
    .WIDTH ($bits(pe_word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (in_valid),
    .push_data  (push_word_s),
    .pop        (m_tready),
    .head_data  (head_word_s),
    .head_valid (head_valid_s),
    .full       (full_s),
    .count_next (count_next_s)
  );

  assign m_tvalid    = head_valid_s;
  assign m_tdata     = head_word_s.data;
  assign m_tlast     = head_word_s.last;
  assign drop_s      = in_valid && full_s;
  assign rd_s        = head_valid_s && m_tready;
  assign overflow    = overflow_r;
  assign almost_full = almost_full_r;
  assign pkt_count   = pkt_count_r;

  // Sticky overflow (set beats clear), packet counter and look-ahead almost-full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r    <= 1'b0;
      almost_full_r <= 1'b0;
      pkt_count_r   <= 16'd0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
      if (rd_s && head_word_s.last) begin
        pkt_count_r <= pkt_count_r + 16'd1;
      end
      almost_full_r <= (count_next_s >= AFULL_C);
    end
  end

endmodule
